// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 message path.
package lcd_pkg;

  localparam int          LCD_LINE_LEN = 16;
  localparam logic [7:0]  LCD_SPACE    = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    SEND,
    GAP,
    DONE
  } lcd_state_e;

endpackage

// File: rtl/lcd_msg_streamer_if.sv
// Host write port plus the ready/msg_byte strobe pair toward the display driver.
interface lcd_msg_streamer_if #(
  parameter int ADDR_W = 5
);
  logic              init_complete;
  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              ready;
  logic [7:0]        msg_byte;
  logic              busy;
  logic              done;

  modport master (
    output init_complete, start, wr_en, wr_addr, wr_data,
    input  ready, msg_byte, busy, done
  );

  modport slave (
    input  init_complete, start, wr_en, wr_addr, wr_data,
    output ready, msg_byte, busy, done
  );
endinterface

// File: rtl/lcd_msg_streamer_gap_timer.sv
// lcd_gap_timer: loadable down-counter; expire flags the decrement that reaches zero.
module lcd_gap_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Asserted on the cycle whose decrement lands on zero, so the caller can leave on that edge.
  assign expire = dec && (cnt == CNT_W'(1));

endmodule

// File: rtl/lcd_msg_streamer.sv
// Streams a 32-byte text buffer into the HD44780 driver, one paced ready strobe per byte.
// Optional build macro LCD_MSG_NUL_STOP_EN: a 0x00 byte ends the message early.
module lcd_msg_streamer
  import lcd_pkg::*;
#(
  parameter int MSG_LEN    = 2 * LCD_LINE_LEN,
  parameter int GAP_CYCLES = 2000,
  parameter int ADDR_W     = $clog2(MSG_LEN)
) (
  input logic               clk,
  input logic               rst_n,
  lcd_msg_streamer_if.slave bus
);

  localparam int                CNT_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

`ifdef LCD_MSG_NUL_STOP_EN
  localparam bit NUL_STOP = 1'b1;
`else
  localparam bit NUL_STOP = 1'b0;
`endif

  logic [7:0]        msg_buf [MSG_LEN];
  lcd_state_e        state;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        cur_byte;
  logic              gap_load;
  logic              gap_dec;
  logic              gap_expire;

  // Read sees the array as of the previous edge, so a same-cycle write is not visible.
  assign cur_byte = msg_buf[idx];
  assign gap_load = (state == SEND);
  assign gap_dec  = (state == GAP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= LCD_SPACE;
    end else if (bus.wr_en) begin
      msg_buf[bus.wr_addr] <= bus.wr_data;
    end
  end

  lcd_gap_timer #(
    .CNT_W (CNT_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (CNT_W'(GAP_CYCLES)),
    .dec      (gap_dec),
    .expire   (gap_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      bus.ready    <= 1'b0;
      bus.msg_byte <= 8'h00;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            state    <= bus.init_complete ? SEND : WAIT_INIT;
          end
        end
        WAIT_INIT: begin
          if (bus.init_complete) state <= SEND;
        end
        SEND: begin
          if (NUL_STOP && cur_byte == 8'h00) begin
            state <= DONE;
          end else begin
            bus.ready    <= 1'b1;
            bus.msg_byte <= cur_byte;
            state        <= GAP;
          end
        end
        GAP: begin
          if (gap_expire) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= SEND;
            end
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          idx      <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_msg_streamer.sv
// Bench for lcd_msg_streamer: shadow buffer model feeds a byte queue checked on every ready strobe.
module tb_lcd_msg_streamer;

  localparam int G    = 4;
  localparam int LEN  = 32;
  localparam int MAXC = LEN * (G + 1) + 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_msg_streamer_if #(.ADDR_W(5)) bus ();

  lcd_msg_streamer #(
    .MSG_LEN    (LEN),
    .GAP_CYCLES (G),
    .ADDR_W     (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] mbuf [LEN];
  logic [7:0] q [$];
  logic [7:0] cap [LEN];
  int cyc = 0;
  int rdy_cnt = 0;
  int done_cnt = 0;
  int last_rdy = 0;
  int first_rdy = 0;
  int exp_done_gap = G + 1;
  bit prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the expected byte per strobe and checks pulse width and spacing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ready) begin
        check("busy_during_ready", 32'(bus.busy), 1);
        if (prev_ready) check("ready_width", 2, 1);
        if (rdy_cnt == 0) first_rdy = cyc;
        else check("ready_spacing", 32'(cyc - last_rdy), G + 1);
        if (q.size() == 0) check("unexpected_ready", 32'(bus.msg_byte), 32'hFFFF);
        else check("msg_byte", 32'(bus.msg_byte), 32'(q.pop_front()));
        if (rdy_cnt < LEN) cap[rdy_cnt] = bus.msg_byte;
        rdy_cnt++;
        last_rdy = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        check("busy_at_done", 32'(bus.busy), 0);
        if (rdy_cnt > 0) check("done_spacing", 32'(cyc - last_rdy), 32'(exp_done_gap));
      end
      prev_ready = bus.ready;
    end
  end

  task automatic load_queue();
    bit hit_nul;
    hit_nul = 1'b0;
    q.delete();
    for (int i = 0; i < LEN; i++) begin
`ifdef LCD_MSG_NUL_STOP_EN
      if (mbuf[i] == 8'h00) begin
        hit_nul = 1'b1;
        break;
      end
`endif
      q.push_back(mbuf[i]);
    end
    exp_done_gap = hit_nul ? G + 2 : G + 1;
    rdy_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    mbuf[a] = d;
    @(negedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic run_stream(input int init_delay);
    int start_cyc, go_cyc, n;
    load_queue();
    n = q.size();
    @(negedge clk); #1;
    bus.init_complete = (init_delay == 0);
    bus.start = 1'b1;
    start_cyc = cyc;
    @(negedge clk); #1;
    bus.start = 1'b0;
    go_cyc = start_cyc;
    if (init_delay > 0) begin
      repeat (init_delay - 1) @(negedge clk);
      #1;
      check("no_ready_before_init", 32'(rdy_cnt), 0);
      check("busy_in_wait_init", 32'(bus.busy), 1);
      bus.init_complete = 1'b1;
      go_cyc = cyc;
    end
    for (int k = 0; k < MAXC; k++) begin
      @(negedge clk); #1;
      if (done_cnt != 0) break;
    end
    check("done_count", 32'(done_cnt), 1);
    check("ready_count", 32'(rdy_cnt), 32'(n));
    check("queue_drained", 32'(q.size()), 0);
    if (n > 0) check("first_ready_latency", 32'(first_rdy - go_cyc), 2);
    check("busy_after_done", 32'(bus.busy), 0);
  endtask

  typedef struct {
    logic [4:0]  base;
    logic [39:0] wbytes;
    int          init_delay;
    logic [39:0] exp_bytes;
  } vec_t;

  vec_t tbl [3];

  initial begin
    logic [7:0] old3;

    tbl[0] = '{5'd0,  "HELLO", 0,  {8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F}};
    tbl[1] = '{5'd27, "WORLD", 10, {8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44}};
    tbl[2] = '{5'd16, "LINE2", 3,  {8'h4C, 8'h49, 8'h4E, 8'h45, 8'h32}};

    for (int i = 0; i < LEN; i++) mbuf[i] = 8'h20;
    bus.init_complete = 1'b0;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", 32'(bus.ready), 0);
    check("reset_msg_byte", 32'(bus.msg_byte), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Power-on buffer streams all spaces.
    run_stream(0);
    for (int j = 0; j < LEN; j++) check("spaces_after_reset", 32'(cap[j]), 32'h20);

    // Second start mid-stream is ignored; write during index 3's SEND cycle is not seen.
    old3 = mbuf[3];
    fork
      run_stream(0);
      begin
        @(negedge clk);
        repeat (16) @(negedge clk);
        #1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 8'h5A;
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
      end
    join
    mbuf[3] = 8'h5A;
    check("idx3_old_byte", 32'(cap[3]), 32'(old3));
    repeat (15) @(negedge clk);
    #1;
    check("no_restart", 32'(rdy_cnt), LEN);
    check("idle_busy", 32'(bus.busy), 0);

    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 5; j++) wr(5'(tbl[r].base + 5'(j)), tbl[r].wbytes[39 - 8*j -: 8]);
      run_stream(tbl[r].init_delay);
      for (int j = 0; j < 5; j++)
        check("tbl_byte", 32'(cap[int'(tbl[r].base) + j]), 32'(tbl[r].exp_bytes[39 - 8*j -: 8]));
      if (r == 0)
        for (int j = 5; j < LEN; j++) check("hello_tail_space", 32'(cap[j]), 32'h20);
    end

    // Reset at index 7 aborts without done and restores spaces.
    load_queue();
    @(negedge clk); #1;
    bus.init_complete = 1'b1;
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < MAXC; k++) begin
      @(negedge clk); #1;
      if (rdy_cnt == 8) break;
    end
    check("reached_index7", 32'(rdy_cnt), 8);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("abort_ready", 32'(bus.ready), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_msg_byte", 32'(bus.msg_byte), 0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < LEN; i++) mbuf[i] = 8'h20;
    repeat (20) @(negedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 0);
    check("abort_no_more_ready", 32'(rdy_cnt), 8);
    run_stream(0);
    for (int j = 0; j < LEN; j++) check("spaces_after_abort", 32'(cap[j]), 32'h20);

    // NUL byte: early stop when the option is built in, otherwise sent as data.
    wr(5'd0, 8'h41);
    wr(5'd1, 8'h42);
    wr(5'd2, 8'h00);
    run_stream(0);
    check("nul_byte0", 32'(cap[0]), 32'h41);
    check("nul_byte1", 32'(cap[1]), 32'h42);
`ifdef LCD_MSG_NUL_STOP_EN
    check("nul_ready_count", 32'(rdy_cnt), 2);
`else
    check("nul_ready_count", 32'(rdy_cnt), LEN);
    check("nul_byte2", 32'(cap[2]), 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
